// File: rtl/serv_immenc_pkg.sv
// Shared encodings for the serial immediate encoder: instruction formats,
// FSM states and which register/opcode fields each format carries.
package serv_immenc_pkg;

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic rd;
    logic funct3;
    logic rs1;
    logic rs2;
  } field_en_t;

  localparam field_en_t EN_I    = '{rd: 1'b1, funct3: 1'b1, rs1: 1'b1, rs2: 1'b0};
  localparam field_en_t EN_S    = '{rd: 1'b0, funct3: 1'b1, rs1: 1'b1, rs2: 1'b1};
  localparam field_en_t EN_B    = '{rd: 1'b0, funct3: 1'b1, rs1: 1'b1, rs2: 1'b1};
  localparam field_en_t EN_U    = '{rd: 1'b1, funct3: 1'b0, rs1: 1'b0, rs2: 1'b0};
  localparam field_en_t EN_J    = '{rd: 1'b1, funct3: 1'b0, rs1: 1'b0, rs2: 1'b0};
  localparam field_en_t EN_NONE = '{rd: 1'b0, funct3: 1'b0, rs1: 1'b0, rs2: 1'b0};

  function automatic field_en_t field_en(input logic [2:0] fmt);
    case (fmt)
      FMT_I:   return EN_I;
      FMT_S:   return EN_S;
      FMT_B:   return EN_B;
      FMT_U:   return EN_U;
      FMT_J:   return EN_J;
      default: return EN_NONE;
    endcase
  endfunction

  function automatic logic fmt_reserved(input logic [2:0] fmt);
    return fmt > FMT_J;
  endfunction

endpackage

// File: rtl/serv_immenc_chk.sv
// Serial representability checker: folds one immediate bit per beat into sign-run and low-bit flags.
// Zero latency from flags to o_err; follows the encoder's beats, so it never stalls anything.
module serv_immenc_chk
  import serv_immenc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_vld,
  input  logic       i_bit,
  input  logic [4:0] i_count,
  input  logic [2:0] i_fmt,
  output logic       o_err
);

  logic all0;
  logic all1;
  logic low_err;
  logic in_range;
  logic low_bad;

  // Sign range starts at the format's top encodable bit; U has none, only low bits must be 0.
  always_comb begin
    in_range = 1'b0;
    low_bad  = 1'b0;
    case (i_fmt)
      FMT_I, FMT_S: in_range = i_count >= 5'd11;
      FMT_B: begin
        in_range = i_count >= 5'd12;
        low_bad  = (i_count == 5'd0) & i_bit;
      end
      FMT_J: begin
        in_range = i_count >= 5'd20;
        low_bad  = (i_count == 5'd0) & i_bit;
      end
      FMT_U:   low_bad = (i_count < 5'd12) & i_bit;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      all0    <= 1'b1;
      all1    <= 1'b1;
      low_err <= 1'b0;
    end else if (i_clr) begin
      all0    <= 1'b1;
      all1    <= 1'b1;
      low_err <= 1'b0;
    end else if (i_vld) begin
      if (in_range) begin
        all0 <= all0 & ~i_bit;
        all1 <= all1 & i_bit;
      end
      if (low_bad) low_err <= 1'b1;
    end
  end

  assign o_err = fmt_reserved(i_fmt) | low_err | ~(all0 | all1);

endmodule

// File: rtl/serv_immenc.sv
// Bit-serial RV32I immediate encoder: 32 accepted beats after i_start, o_valid one cycle after the last.
// Serial input stalls freely via i_imm_valid; output holds in DONE until i_ready.
module serv_immenc
  import serv_immenc_pkg::*;
#(
  parameter bit WITH_CHECK = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic        i_imm_valid,
  input  logic        i_imm,
  output logic        o_imm_ready,
  output logic        o_busy,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_insn,
  output logic        o_err
);

  state_e      state;
  logic [2:0]  fmt_q;
  logic [4:0]  count;
  logic [31:0] insn_q;
  logic        valid_q;
  logic        busy_q;
  logic        rdy_q;
  logic        start;
  logic        beat;
  logic        map_vld;
  logic [4:0]  map_pos;
  logic [31:0] insn_init;
  field_en_t   fe;
  logic        err;

  assign start = (state == ST_IDLE) & i_start;
  assign beat  = rdy_q & i_imm_valid;

  always_comb begin
    fe        = field_en(i_fmt);
    insn_init = {7'd0,
                 fe.rs2    ? i_rs2    : 5'd0,
                 fe.rs1    ? i_rs1    : 5'd0,
                 fe.funct3 ? i_funct3 : 3'd0,
                 fe.rd     ? i_rd     : 5'd0,
                 i_opcode};
  end

  // Instruction bit position for immediate bit 'count'; map_vld=0 drops the bit.
  always_comb begin
    map_vld = 1'b0;
    map_pos = 5'd0;
    case (fmt_q)
      FMT_I: if (count <= 5'd11) begin map_vld = 1'b1; map_pos = count + 5'd20; end
      FMT_S: begin
        if (count <= 5'd4) begin map_vld = 1'b1; map_pos = count + 5'd7; end
        else if (count <= 5'd11) begin map_vld = 1'b1; map_pos = count + 5'd20; end
      end
      FMT_B: begin
        if (count == 5'd12) begin map_vld = 1'b1; map_pos = 5'd31; end
        else if (count == 5'd11) begin map_vld = 1'b1; map_pos = 5'd7; end
        else if (count >= 5'd5 && count <= 5'd10) begin map_vld = 1'b1; map_pos = count + 5'd20; end
        else if (count >= 5'd1 && count <= 5'd4) begin map_vld = 1'b1; map_pos = count + 5'd7; end
      end
      FMT_U: if (count >= 5'd12) begin map_vld = 1'b1; map_pos = count; end
      FMT_J: begin
        if (count == 5'd20) begin map_vld = 1'b1; map_pos = 5'd31; end
        else if (count == 5'd11) begin map_vld = 1'b1; map_pos = 5'd20; end
        else if (count >= 5'd12 && count <= 5'd19) begin map_vld = 1'b1; map_pos = count; end
        else if (count >= 5'd1 && count <= 5'd10) begin map_vld = 1'b1; map_pos = count + 5'd20; end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      fmt_q   <= FMT_I;
      count   <= 5'd0;
      insn_q  <= 32'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (i_start) begin
          state  <= ST_SHIFT;
          fmt_q  <= i_fmt;
          count  <= 5'd0;
          insn_q <= insn_init;
          rdy_q  <= 1'b1;
          busy_q <= 1'b1;
        end
        ST_SHIFT: if (i_imm_valid) begin
          if (map_vld) insn_q[map_pos] <= i_imm;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            state   <= ST_DONE;
            rdy_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        ST_DONE: if (i_ready) begin
          state   <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  generate
    if (WITH_CHECK) begin : g_chk
      serv_immenc_chk u_chk (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (start),
        .i_vld   (beat),
        .i_bit   (i_imm),
        .i_count (count),
        .i_fmt   (fmt_q),
        .o_err   (err)
      );
    end else begin : g_nochk
      assign err = 1'b0;
    end
  endgenerate

  assign o_imm_ready = rdy_q;
  assign o_busy      = busy_q;
  assign o_valid     = valid_q;
  assign o_insn      = insn_q;
  assign o_err       = err;

endmodule

// File: tb/tb_serv_immenc.sv
// Bench for serv_immenc: directed scenarios plus randomized encodes against a field-concatenation model.
module tb_serv_immenc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic        imm_vld, imm_bit, rdy;
  logic        imm_ready, busy, valid, err;
  logic [31:0] insn;
  logic        imm_ready_n, busy_n, valid_n, err_n;
  logic [31:0] insn_n;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  serv_immenc #(.WITH_CHECK(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_fmt(fmt), .i_opcode(opcode),
    .i_funct3(funct3), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_imm_valid(imm_vld),
    .i_imm(imm_bit), .o_imm_ready(imm_ready), .o_busy(busy), .o_valid(valid),
    .i_ready(rdy), .o_insn(insn), .o_err(err)
  );

  serv_immenc #(.WITH_CHECK(1'b0)) dut_nc (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_fmt(fmt), .i_opcode(opcode),
    .i_funct3(funct3), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_imm_valid(imm_vld),
    .i_imm(imm_bit), .o_imm_ready(imm_ready_n), .o_busy(busy_n), .o_valid(valid_n),
    .i_ready(rdy), .o_insn(insn_n), .o_err(err_n)
  );

  // Reference: the RV32I field layouts written directly as concatenations.
  function automatic logic [31:0] ref_insn(input logic [2:0] f, input logic [6:0] op,
      input logic [2:0] f3, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [31:0] imm);
    case (f)
      3'd0:    return {imm[11:0], s1, f3, d, op};
      3'd1:    return {imm[11:5], s2, s1, f3, imm[4:0], op};
      3'd2:    return {imm[12], imm[10:5], s2, s1, f3, imm[4:1], imm[11], op};
      3'd3:    return {imm[31:12], d, op};
      3'd4:    return {imm[20], imm[10:1], imm[11], imm[19:12], d, op};
      default: return {25'd0, op};
    endcase
  endfunction

  // Reference: signed range of each format's immediate.
  function automatic logic ref_err(input logic [2:0] f, input logic [31:0] imm);
    int v;
    v = $signed(imm);
    case (f)
      3'd0, 3'd1: return (v < -2048) || (v > 2047);
      3'd2:       return (v < -4096) || (v > 4095) || imm[0];
      3'd3:       return imm[11:0] != 12'd0;
      3'd4:       return (v < -(1 << 20)) || (v > (1 << 20) - 1) || imm[0];
      default:    return 1'b1;
    endcase
  endfunction

  // Drives one encode until o_valid; stall 0=none, 1=every other cycle, 2=random.
  task automatic run_enc(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] imm,
      input int stall, output int lat, output bit to);
    int k;
    int cyc;
    @(negedge clk);
    fmt = f; opcode = op; funct3 = f3; rd = d; rs1 = s1; rs2 = s2;
    start = 1'b1; imm_vld = 1'b0;
    @(negedge clk);
    start = 1'b0;
    fmt = 3'($urandom); opcode = 7'($urandom); funct3 = 3'($urandom);
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    cyc = 1; k = 0; to = 1'b0;
    while (!valid && !to) begin
      if (k < 32 && imm_ready &&
          (stall == 0 || (stall == 1 && cyc % 2 == 0) ||
           (stall == 2 && $urandom_range(0, 2) != 0))) begin
        imm_vld = 1'b1; imm_bit = imm[k]; k++;
      end else begin
        imm_vld = 1'b0; imm_bit = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
      if (cyc > 400) to = 1'b1;
    end
    imm_vld = 1'b0;
    lat = cyc;
  endtask

  task automatic handshake();
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; imm_vld = 1'b0; imm_bit = 1'b0; rdy = 1'b0;
    fmt = 3'd0; opcode = 7'd0; funct3 = 3'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    #12;
    total++; if (insn !== 32'd0) begin bad++; $display("FAIL reset_insn: got %h want 0", insn); end
    total++; if ({imm_ready, busy, valid, err} !== 4'b0) begin
      bad++; $display("FAIL reset_flags: got rdy/busy/vld/err=%b want 0000", {imm_ready, busy, valid, err});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_i_basic();
    int lat; bit to;
    run_enc(3'd0, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 0, lat, to);
    total++; if (to || lat != 33) begin bad++; $display("FAIL i_latency: got %0d to=%0d want 33", lat, to); end
    total++; if (insn !== 32'hFFF1_0093) begin bad++; $display("FAIL i_insn: got %h want fff10093", insn); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL i_err: got %b want 0", err); end
    handshake();
    total++; if (valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL i_handshake: got valid=%b busy=%b want 0 0", valid, busy);
    end
  endtask

  task automatic test_s_stall();
    int lat; bit to;
    run_enc(3'd1, 7'h23, 3'd2, 5'd0, 5'd2, 5'd5, 32'd8, 1, lat, to);
    total++; if (to || lat != 65) begin bad++; $display("FAIL s_latency: got %0d to=%0d want 65", lat, to); end
    total++; if (insn !== 32'h0051_2423) begin bad++; $display("FAIL s_insn: got %h want 00512423", insn); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL s_err: got %b want 0", err); end
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat; bit to;
    run_enc(3'd2, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 0, lat, to);
    total++; if (to || insn !== 32'hFE00_0EE3) begin bad++; $display("FAIL b_insn: got %h want fe000ee3", insn); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL b_err: got %b want 0", err); end
    fmt = 3'd3; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (valid !== 1'b1 || insn !== 32'hFE00_0EE3 || imm_ready !== 1'b0) begin
        bad++; $display("FAIL b_hold: cyc %0d got valid=%b insn=%h want 1 fe000ee3", i, valid, insn);
      end
    end
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0; start = 1'b0;
    total++; if (valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL b_start_ignored: got valid=%b busy=%b want 0 0", valid, busy);
    end
    run_enc(3'd3, 7'h37, 3'd0, 5'd1, 5'd0, 5'd0, 32'h1234_5000, 0, lat, to);
    total++; if (to || insn !== 32'h1234_50B7) begin bad++; $display("FAIL u_insn: got %h want 123450b7", insn); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL u_err: got %b want 0", err); end
    handshake();
  endtask

  task automatic test_errors();
    logic [2:0]  fs[4]  = '{3'd0, 3'd4, 3'd3, 3'd6};
    logic [31:0] ims[4] = '{32'h0000_0800, 32'h0000_0003, 32'h0000_0001, 32'hDEAD_BEEF};
    int lat; bit to;
    for (int i = 0; i < 4; i++) begin
      run_enc(fs[i], 7'h5B, 3'd5, 5'd9, 5'd10, 5'd11, ims[i], 0, lat, to);
      total++; if (to || err !== 1'b1) begin bad++; $display("FAIL err_case%0d: got %b want 1", i, err); end
      total++; if (insn !== ref_insn(fs[i], 7'h5B, 3'd5, 5'd9, 5'd10, 5'd11, ims[i])) begin
        bad++; $display("FAIL err_insn%0d: got %h want %h", i, insn,
                        ref_insn(fs[i], 7'h5B, 3'd5, 5'd9, 5'd10, 5'd11, ims[i]));
      end
      total++; if (err_n !== 1'b0 || valid_n !== 1'b1) begin
        bad++; $display("FAIL nochk_err%0d: got err=%b valid=%b want 0 1", i, err_n, valid_n);
      end
      handshake();
    end
  endtask

  task automatic test_reset_abort();
    int lat; bit to;
    @(negedge clk);
    fmt = 3'd0; opcode = 7'h13; funct3 = 3'd1; rd = 5'd3; rs1 = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      imm_vld = 1'b1; imm_bit = 1'b1;
      @(negedge clk);
    end
    imm_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if ({imm_ready, busy, valid, err} !== 4'b0 || insn !== 32'd0) begin
      bad++; $display("FAIL abort_outputs: got rdy/busy/vld/err=%b insn=%h want 0000 0",
                      {imm_ready, busy, valid, err}, insn);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_enc(3'd0, 7'h13, 3'd1, 5'd3, 5'd4, 5'd0, 32'hFFFF_F800, 0, lat, to);
    total++; if (to || insn !== 32'h8002_1193) begin bad++; $display("FAIL abort_reencode: got %h want 80021193", insn); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL abort_err: got %b want 0", err); end
    handshake();
  endtask

  task automatic test_random();
    logic [2:0] f; logic [6:0] op; logic [2:0] f3; logic [4:0] d, s1, s2;
    logic [31:0] imm, exp_i; logic exp_e;
    int lat, stall; bit to;
    for (int n = 0; n < 24; n++) begin
      f = 3'($urandom_range(0, 7)); op = 7'($urandom); f3 = 3'($urandom);
      d = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
      case ($urandom_range(0, 2))
        0:       imm = $urandom;
        1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        default: imm = {20'($urandom), 12'd0};
      endcase
      stall = (n % 2 == 0) ? 0 : 2;
      exp_i = ref_insn(f, op, f3, d, s1, s2, imm);
      exp_e = ref_err(f, imm);
      run_enc(f, op, f3, d, s1, s2, imm, stall, lat, to);
      total++; if (to || (stall == 0 && lat != 33)) begin
        bad++; $display("FAIL rnd_latency%0d: got %0d to=%0d", n, lat, to);
      end
      total++; if (insn !== exp_i || insn_n !== exp_i) begin
        bad++; $display("FAIL rnd_insn%0d: fmt=%0d imm=%h got %h/%h want %h", n, f, imm, insn, insn_n, exp_i);
      end
      total++; if (err !== exp_e || err_n !== 1'b0) begin
        bad++; $display("FAIL rnd_err%0d: fmt=%0d imm=%h got %b/%b want %b/0", n, f, imm, err, err_n, exp_e);
      end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_i_basic();
    test_s_stall();
    test_back_to_back();
    test_errors();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serv_immenc.md
Name: serv_immenc

Overview:
Bit-serial immediate encoder; the inverse of the immediate decoder. It takes register/opcode fields in parallel and a 32-bit immediate LSB-first, one bit per accepted cycle. It scatters each bit into its RV32I instruction position for the selected format and presents the assembled 32-bit instruction word on a valid/ready output. It also flags immediates that the format cannot represent. Used by the debug/program-buffer path and self-test generators to synthesize instructions without a parallel shifter.

Parameters:
WITH_CHECK, 1, 1 = representability checking present; 0 = o_err tied to 0 and check logic removed.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  begin encode; sampled only in IDLE
i_fmt  in  3  0=I 1=S 2=B 3=U 4=J; 5..7 reserved
i_opcode  in  7  opcode field, insn[6:0]
i_funct3  in  3  insn[14:12] (I/S/B)
i_rd  in  5  insn[11:7] (I/U/J)
i_rs1  in  5  insn[19:15] (I/S/B)
i_rs2  in  5  insn[24:20] (S/B)
i_imm_valid  in  1  serial immediate bit valid
i_imm  in  1  immediate bit; bit k on k-th accepted beat, k=0..31
o_imm_ready  out  1  high in SHIFT; beat accepted when i_imm_valid & o_imm_ready
o_busy  out  1  state != IDLE
o_valid  out  1  instruction available
i_ready  in  1  consumer accepts o_insn
o_insn  out  32  assembled instruction
o_err  out  1  immediate not representable or reserved fmt; qualified by o_valid

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, count 0, o_insn 0, o_valid 0, o_err 0, o_busy 0, o_imm_ready 0.
- FSM IDLE -> SHIFT on i_start. Capture fmt and count=0. Load o_insn with opcode and the format's fields; fields a format does not use are 0. R-type fields are not supported.
- SHIFT: each accepted beat writes bit k to its target position and increments the 5-bit count. No beat means no state change, so stalls of any length are allowed.
- SHIFT -> DONE on the beat where count==31. o_valid rises the next cycle. Minimum latency from i_start to o_valid is 33 cycles.
- DONE: o_valid=1, o_insn and o_err stable. DONE -> IDLE on o_valid & i_ready. o_valid drops the next cycle.
- i_start in SHIFT or DONE is ignored. i_start in the same cycle as the DONE handshake is ignored; the next start is honoured from IDLE.
- Bit mapping (immediate bit -> insn bit); unlisted bits are dropped:
  - I: imm[11:0] -> [31:20]
  - S: imm[11:5] -> [31:25]; imm[4:0] -> [11:7]
  - B: imm[12] -> 31; imm[10:5] -> [30:25]; imm[4:1] -> [11:8]; imm[11] -> 7
  - U: imm[31:12] -> [31:12]
  - J: imm[20] -> 31; imm[10:1] -> [30:21]; imm[11] -> 20; imm[19:12] -> [19:12]
- Representability check, evaluated at DONE:
  - Track running all-ones and all-zeros flags over the format's sign range: I/S bits [31:11], B [31:12], J [31:20]. err = !(all0 | all1).
  - B/J: err also if imm[0]=1.
  - U: err if any of imm[11:0] is 1.
  - Reserved fmt: err=1 and o_insn=opcode only; bits are still consumed for 32 beats.
  - Flags are reset at start.
- Reset asserted mid-SHIFT or in DONE aborts immediately. No partial output survives.

Decomposition:
- Shared package holds the format encodings (FMT_I..FMT_J) and the per-format field-enable constants.
- One natural sub-module, serv_immenc_chk: the serial representability checker, taking bit, count, fmt and clear, and outputting err. It is omitted when WITH_CHECK=0.
- The bit-mapping mux and the FSM stay in the top module.

Test Plan:
- I: opcode 0x13, rd 1, rs1 2, funct3 0, imm 0xFFFFFFFF, no stalls -> o_valid at cycle 33, o_insn 0xFFF10093, o_err 0.
- S: opcode 0x23, rs1 2, rs2 5, funct3 2, imm 8, i_imm_valid toggling every other cycle -> o_insn 0x00512423, o_valid at cycle 65.
- B then U back-to-back:
  - B: opcode 0x63, rs1 0, rs2 0, funct3 0, imm 0xFFFFFFFC -> 0xFE000EE3.
  - U: opcode 0x37, rd 1, imm 0x12345000 -> 0x123450B7.
  - i_ready held low for 5 cycles in DONE -> o_insn stable and second i_start ignored until the handshake completes.
- Errors:
  - I with imm 0x00000800 -> o_err 1.
  - J with imm 0x00000003 -> o_err 1.
  - U with imm 0x00000001 -> o_err 1.
  - fmt 6 -> o_err 1, o_insn = opcode.
  - WITH_CHECK=0 -> o_err always 0.
- Reset: assert i_rst_n=0 after 10 beats -> all outputs 0 immediately. A fresh I encode afterwards yields the correct word with o_err 0.
